// File: rtl/ov7670_grid_sampler_if.sv
// Camera-side bus of the grid sampler: VSYNC/HREF/PCLK/D stream in, XCLK out.
// master = camera (or camera model), slave = sampler.
interface ov7670_grid_sampler_if;
  logic       VSYNC;
  logic       HREF;
  logic       PCLK;
  logic [7:0] D;
  logic       XCLK;

  modport master (output VSYNC, HREF, PCLK, D, input XCLK);
  modport slave  (input VSYNC, HREF, PCLK, D, output XCLK);
endinterface

// File: rtl/ov7670_grid_sampler.sv
// Samples a GRID x GRID lattice of RGB565 points (optionally run-averaged) per camera frame.
// Pixel write lands on the cycle the low byte arrives; readback is 1-cycle registered; no backpressure.
module ov7670_grid_sampler #(
  parameter int LINES    = 140,
  parameter int COLUMNS  = 320,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9,
  parameter int GRID     = 3,
  parameter int ROW0     = 19,
  parameter int ROW_STEP = 40,
  parameter int COL0     = 79,
  parameter int COL_STEP = 80,
  parameter int AVG_LOG2 = 0,
  parameter int XCLK_DIV = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  ov7670_grid_sampler_if.slave cam,
  input  logic [1:0]           rd_line,
  input  logic [1:0]           rd_column,
  output logic [15:0]          pixel,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_error
);

  localparam int NPTS = GRID * GRID;
  localparam int RUN  = 1 << AVG_LOG2;
  localparam int AW   = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int RW   = 5 + AVG_LOG2;
  localparam int GW   = 6 + AVG_LOG2;
  localparam int CW   = 5;
  localparam int XW   = $clog2(XCLK_DIV);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;

  state_t              state;
  logic                pclk_q, href_q, vsync_q;
  logic [S_LINE-1:0]   line;
  logic [S_COLUMN-1:0] column;
  logic                phase;
  logic [7:0]          hi_byte;
  logic [RW-1:0]       acc_r;
  logic [GW-1:0]       acc_g;
  logic [RW-1:0]       acc_b;
  logic [CW-1:0]       wr_cnt;
  logic [15:0]         buffer [NPTS];
  logic [XW-1:0]       xclk_cnt;
  logic                xclk_q;

  logic                pclk_rise, href_fall, frame_start, frame_end;
  logic                byte_en, pix_vld;
  logic [15:0]         pix_dat;
  logic                row_hit, col_hit, hit, run_first, run_last, wr_en;
  logic [1:0]          row_idx, col_idx;
  logic [2:0]          col_off;
  logic [RW-1:0]       sum_r, sum_b;
  logic [GW-1:0]       sum_g;
  logic [15:0]         wr_dat;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                rd_ok;

  assign pclk_rise   = cam.PCLK & ~pclk_q;
  assign href_fall   = ~cam.HREF & href_q;
  assign frame_start = ~cam.VSYNC & vsync_q;
  assign frame_end   = cam.VSYNC & ~vsync_q;
  assign cam.XCLK    = xclk_q;

  // frame_end wins over a byte arriving in the same cycle
  assign byte_en = (state == CAPTURE) && cam.HREF && pclk_rise && !frame_end;
  assign pix_vld = byte_en && phase;
  assign pix_dat = {hi_byte, cam.D};

  always_comb begin
    row_hit = 1'b0;
    row_idx = '0;
    col_hit = 1'b0;
    col_idx = '0;
    col_off = '0;
    for (int r = 0; r < GRID; r++) begin
      if (int'(line) == ROW0 + r * ROW_STEP) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
    for (int c = 0; c < GRID; c++) begin
      if (int'(column) >= COL0 + c * COL_STEP && int'(column) < COL0 + c * COL_STEP + RUN) begin
        col_hit = 1'b1;
        col_idx = 2'(c);
        col_off = 3'(int'(column) - (COL0 + c * COL_STEP));
      end
    end
  end

  assign hit       = pix_vld && row_hit && col_hit;
  assign run_first = (col_off == 3'd0);
  assign run_last  = (col_off == 3'(RUN - 1));
  assign wr_en     = hit && run_last;

  // first pixel of a run loads, later pixels add
  assign sum_r   = (run_first ? '0 : acc_r) + RW'(pix_dat[15:11]);
  assign sum_g   = (run_first ? '0 : acc_g) + GW'(pix_dat[10:5]);
  assign sum_b   = (run_first ? '0 : acc_b) + RW'(pix_dat[4:0]);
  assign wr_dat  = {5'(sum_r >> AVG_LOG2), 6'(sum_g >> AVG_LOG2), 5'(sum_b >> AVG_LOG2)};
  assign wr_addr = AW'(int'(row_idx) * GRID + int'(col_idx));

  assign rd_ok   = (int'(rd_line) < GRID) && (int'(rd_column) < GRID);
  assign rd_addr = AW'(int'(rd_line) * GRID + int'(rd_column));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      pclk_q      <= 1'b0;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      line        <= '0;
      column      <= '0;
      phase       <= 1'b0;
      hi_byte     <= '0;
      acc_r       <= '0;
      acc_g       <= '0;
      acc_b       <= '0;
      wr_cnt      <= '0;
      xclk_cnt    <= '0;
      xclk_q      <= 1'b0;
      pixel       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < NPTS; i++) buffer[i] <= '0;
    end else begin
      pclk_q   <= cam.PCLK;
      href_q   <= cam.HREF;
      vsync_q  <= cam.VSYNC;
      xclk_cnt <= (int'(xclk_cnt) == XCLK_DIV - 1) ? '0 : xclk_cnt + 1'b1;
      xclk_q   <= (int'(xclk_cnt) == XCLK_DIV - 1);

      // read-before-write: a same-cycle write is not visible until the next read
      pixel <= rd_ok ? buffer[rd_addr] : '0;
      if (wr_en) buffer[wr_addr] <= wr_dat;
      if (hit) begin
        acc_r <= sum_r;
        acc_g <= sum_g;
        acc_b <= sum_b;
      end
      if (wr_en && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;

      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WAIT_FRAME;
            busy        <= 1'b1;
            frame_error <= 1'b0;
            wr_cnt      <= '0;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            state  <= CAPTURE;
            line   <= '0;
            column <= '0;
            phase  <= 1'b0;
            wr_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (frame_end) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            if (wr_cnt != CW'(NPTS)) frame_error <= 1'b1;
          end else if (href_fall) begin
            column <= '0;
            phase  <= 1'b0;
            line   <= (int'(line) == LINES - 1) ? line : line + 1'b1;
          end else if (byte_en) begin
            phase <= ~phase;
            if (!phase) hi_byte <= cam.D;
            else column <= (int'(column) == COLUMNS - 1) ? column : column + 1'b1;
          end
        end
        default: begin
          if (continuous) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_grid_sampler.sv
// Scoreboard bench for ov7670_grid_sampler: directed frames, queued read/frame_done expectations.
module tb_ov7670_grid_sampler;

  logic        clock = 1'b0;
  logic        reset, start, start_avg, continuous;
  logic [1:0]  rd_line, rd_column;
  logic [15:0] pixel, pixel_avg;
  logic        busy, frame_done, frame_error;
  logic        busy_avg, done_avg, err_avg;
  logic        rd_req, rd_req_avg, rd_req_q, rd_req_avg_q, rst_q;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] rd_q[$];
  logic [15:0] rd_avg_q[$];
  logic        done_q[$];
  logic [15:0] mdl [9];

  always #5 clock = ~clock;

  ov7670_grid_sampler_if cam();
  ov7670_grid_sampler_if cam_avg();

  assign cam_avg.VSYNC = cam.VSYNC;
  assign cam_avg.HREF  = cam.HREF;
  assign cam_avg.PCLK  = cam.PCLK;
  assign cam_avg.D     = cam.D;

  ov7670_grid_sampler dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous), .cam(cam),
    .rd_line(rd_line), .rd_column(rd_column), .pixel(pixel), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  ov7670_grid_sampler #(.AVG_LOG2(2)) dut_avg (
    .clock(clock), .reset(reset), .start(start_avg), .continuous(1'b0), .cam(cam_avg),
    .rd_line(rd_line), .rd_column(rd_column), .pixel(pixel_avg), .busy(busy_avg),
    .frame_done(done_avg), .frame_error(err_avg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    rd_req_q     <= rd_req;
    rd_req_avg_q <= rd_req_avg;
    rst_q        <= reset;
  end

  // monitor: reads complete one cycle after request; frame_done pops an expected frame_error
  int cyc = 0;
  int xlast = -1;
  always @(negedge clock) begin
    if (rd_req_q === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: actual=%0h required=none", pixel);
      end else check("read", pixel, rd_q.pop_front());
    end
    if (rd_req_avg_q === 1'b1) begin
      if (rd_avg_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_avg_unexpected: actual=%0h required=none", pixel_avg);
      end else check("read_avg", pixel_avg, rd_avg_q.pop_front());
    end
    if (frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_done_unexpected: actual=1 required=0");
      end else check("frame_error_at_done", frame_error, done_q.pop_front());
    end
    if (rst_q !== 1'b1) xlast = -1;
    else if (cam.XCLK === 1'b1) begin
      if (xlast >= 0) check("xclk_period", cyc - xlast, 5);
      xlast = cyc;
    end
    cyc++;
  end

  function automatic logic [15:0] pix_val(input int mode, input int l, input int c);
    logic [15:0] base;
    base = 16'((l << 9) | c);
    case (mode)
      0:       return base;
      1:       return (c % 2 == 1) ? 16'hF800 : 16'h0000;
      2:       return ~base;
      default: return base ^ 16'h5A5A;
    endcase
  endfunction

  task automatic update_model(input int mode, input int nlines);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (19 + 40 * r < nlines) mdl[r * 3 + c] = pix_val(mode, 19 + 40 * r, 79 + 80 * c);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam.PCLK = 1'b0;
    cam.D    = b;
    @(negedge clock);
    cam.PCLK = 1'b1;
    @(negedge clock);
  endtask

  // only sample rows carry a full line; other lines carry one pixel to save time
  task automatic send_line(input int mode, input int l, input bit odd);
    int npx;
    logic [15:0] v;
    npx = (l == 19 || l == 59 || l == 99) ? 320 : 1;
    cam.HREF = 1'b1;
    for (int px = 0; px < npx; px++) begin
      v = pix_val(mode, l, px);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
    end
    if (odd) send_byte(8'hAA);
    cam.PCLK = 1'b0;
    cam.HREF = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_frame(input int mode, input int nlines, input bit odd, input bit do_end);
    cam.VSYNC = 1'b0;
    repeat (2) @(negedge clock);
    for (int l = 0; l < nlines; l++) send_line(mode, l, odd);
    if (do_end) begin
      cam.VSYNC = 1'b1;
      repeat (6) @(negedge clock);
    end
  endtask

  task automatic pulse_start(input bit with_avg);
    start     = 1'b1;
    start_avg = with_avg;
    @(negedge clock);
    start     = 1'b0;
    start_avg = 1'b0;
    @(negedge clock);
  endtask

  task automatic rd(input int l, input int c, input logic [15:0] e, input bit avg);
    rd_line    = 2'(l);
    rd_column  = 2'(c);
    rd_req     = !avg;
    rd_req_avg = avg;
    if (avg) rd_avg_q.push_back(e);
    else rd_q.push_back(e);
    @(negedge clock);
    rd_req     = 1'b0;
    rd_req_avg = 1'b0;
  endtask

  task automatic read_all();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) rd(r, c, mdl[r * 3 + c], 1'b0);
    rd(3, 0, 16'h0000, 1'b0);
    rd(0, 3, 16'h0000, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_avg = 1'b0; continuous = 1'b0;
    cam.VSYNC = 1'b1; cam.HREF = 1'b0; cam.PCLK = 1'b0; cam.D = 8'h00;
    rd_line = '0; rd_column = '0; rd_req = 1'b0; rd_req_avg = 1'b0;
    for (int i = 0; i < 9; i++) mdl[i] = 16'h0000;

    repeat (3) @(negedge clock);
    check("reset_pixel", pixel, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_xclk", cam.XCLK, 0);
    check("reset_pixel_avg", pixel_avg, 0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // reset abandons a capture after line 30 (row 0 already written)
    pulse_start(1'b0);
    check("busy_after_start", busy, 1);
    send_frame(0, 31, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("busy_after_reset", busy, 0);
    cam.VSYNC = 1'b1;
    repeat (4) @(negedge clock);
    read_all();

    // full default frame
    pulse_start(1'b0);
    done_q.push_back(1'b0);
    send_frame(0, 140, 1'b0, 1'b1);
    check("busy_idle_after_frame", busy, 0);
    check("frame_error_clean", frame_error, 0);
    update_model(0, 140);
    read_all();
    rd(1, 2, 16'h76EF, 1'b0);
    rd(0, 0, 16'h264F, 1'b0);
    @(negedge clock);

    // alternating red/black runs; averaging instance halves red
    pulse_start(1'b1);
    done_q.push_back(1'b0);
    send_frame(1, 140, 1'b0, 1'b1);
    update_model(1, 140);
    read_all();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) rd(r, c, 16'h7800, 1'b1);
    rd(3, 3, 16'h0000, 1'b1);
    @(negedge clock);
    check("avg_frame_error", err_avg, 0);

    // frame cut short after line 70: row 2 keeps the previous frame
    pulse_start(1'b0);
    done_q.push_back(1'b1);
    send_frame(2, 71, 1'b0, 1'b1);
    check("frame_error_sticky", frame_error, 1);
    update_model(2, 71);
    read_all();

    // start mid-frame: that frame is skipped, then continuous frames
    cam.VSYNC = 1'b0;
    repeat (2) @(negedge clock);
    for (int l = 0; l < 10; l++) send_line(2, l, 1'b0);
    continuous = 1'b1;
    pulse_start(1'b0);
    check("busy_mid_frame_start", busy, 1);
    for (int l = 10; l < 15; l++) send_line(2, l, 1'b0);
    cam.VSYNC = 1'b1;
    repeat (6) @(negedge clock);
    check("busy_wait_after_skipped", busy, 1);
    check("frame_error_cleared", frame_error, 0);

    done_q.push_back(1'b0);
    send_frame(0, 140, 1'b0, 1'b1);
    check("busy_continuous", busy, 1);
    update_model(0, 140);
    read_all();

    // odd byte count per line; continuous dropped so the block parks in IDLE
    continuous = 1'b0;
    done_q.push_back(1'b0);
    send_frame(3, 140, 1'b1, 1'b1);
    check("busy_after_last", busy, 0);
    update_model(3, 140);
    read_all();

    repeat (5) @(negedge clock);
    check("done_queue_drained", done_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);
    check("read_avg_queue_drained", rd_avg_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_grid_sampler.md
Name: ov7670_grid_sampler

Overview:
- Parametrised successor of the OV7670 capture datapath, with its own control FSM.
- Assembles RGB565 pixels from the camera byte stream and samples a GRID x GRID lattice of points per frame.
- Each sample point optionally averages a horizontal run of 2^AVG_LOG2 pixels.
- Results are stored in an internal GRID*GRID buffer that the colour-classification logic reads back after frame_done.

Parameters:
LINES, 140, active lines counted per frame (line counter saturates at LINES-1)
COLUMNS, 320, pixels per line (column counter saturates at COLUMNS-1)
S_LINE, 8, line counter width
S_COLUMN, 9, column counter width
GRID, 3, sample points per axis (1..4)
ROW0, 19, first sample line
ROW_STEP, 40, line spacing between sample rows
COL0, 79, first sample column
COL_STEP, 80, column spacing between sample columns
AVG_LOG2, 0, log2 of pixels averaged per sample (0..3)
XCLK_DIV, 5, XCLK period in clock cycles (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  arm capture of the next full frame (one-cycle pulse)
continuous  in  1  when 1, re-arm automatically after each frame
VSYNC  in  1  camera vsync, high = vertical blanking (pre-synchronised to clock)
HREF  in  1  camera line-valid (pre-synchronised)
PCLK  in  1  camera pixel clock (pre-synchronised, sampled as data)
D  in  8  camera data byte
rd_line  in  2  readback row index
rd_column  in  2  readback column index
pixel  out  16  RGB565 sample at (rd_line, rd_column), 1-cycle registered read
busy  out  1  high in WAIT_FRAME and CAPTURE
frame_done  out  1  one-cycle pulse when a capture ends
frame_error  out  1  sticky until next start; frame ended before all samples were written
XCLK  out  1  camera clock: one-cycle-high pulse every XCLK_DIV cycles

Behaviour:
- Reset (reset=0 at a clock edge):
  - state IDLE; all counters and byte phase 0.
  - Buffer cleared to 0.
  - pixel, busy, frame_done, frame_error, XCLK all 0.
  - Applies from any state; an in-flight capture is abandoned with no frame_done.
- Edge detection: registered copies of PCLK, HREF, VSYNC.
  - pclk_rise = PCLK & ~PCLK_q.
  - href_fall = ~HREF & HREF_q.
  - frame_start = ~VSYNC & VSYNC_q.
  - frame_end = VSYNC & ~VSYNC_q.
- FSM:
  - IDLE: start=1 -> WAIT_FRAME. Clears frame_error and the sample counters.
  - WAIT_FRAME: frame_start -> CAPTURE, with line, column and byte phase reset to 0. A capture never begins mid-frame.
  - CAPTURE: frame_end -> DONE.
  - DONE (one cycle): frame_done=1. Then -> WAIT_FRAME if continuous=1, else IDLE.
  - start is ignored outside IDLE.
- Byte assembly (CAPTURE, HREF=1, on pclk_rise):
  - Phase 0 latches D as the high byte.
  - Phase 1 forms {high,D} and asserts pix_valid for one cycle; column increments, saturating at COLUMNS-1.
  - Phase toggles on each byte.
- On href_fall:
  - Column and phase clear.
  - Line increments, saturating at LINES-1.
  - An odd trailing byte is discarded.
- Sample hit:
  - line == ROW0+r*ROW_STEP for some r<GRID.
  - column in [COL0+c*COL_STEP, COL0+c*COL_STEP+2^AVG_LOG2-1] for some c<GRID.
  - Match constants are computed at elaboration.
- Accumulation:
  - Per-channel accumulators: R 5+AVG_LOG2 bits, G 6+AVG_LOG2 bits, B 5+AVG_LOG2 bits.
  - The first pixel of a run loads the accumulators; later pixels in the run add.
  - The last pixel of the run writes {R>>AVG_LOG2, G>>AVG_LOG2, B>>AVG_LOG2} (truncating) to address r*GRID+c in the same cycle.
  - With AVG_LOG2=0 the raw pixel is written.
- Write counter counts samples written.
  - At frame_end, if count != GRID*GRID, set frame_error.
  - A partial run is discarded. Buffer entries not rewritten keep their previous frame's value.
- Read port:
  - pixel <= buffer[rd_line*GRID+rd_column] every cycle.
  - Indices >= GRID return 0.
  - A read of an address being written in the same cycle returns the old value.
- XCLK runs freely from reset release, independent of FSM state.

Test Plan:
- Reset mid-CAPTURE (reset=0 for 1 cycle after line 30) -> state IDLE, busy=0, no frame_done, all 9 reads return 0x0000.
- Defaults: start, full 140x320 frame, pixel value = {line,column} truncated to 16 bits -> frame_done once, frame_error=0, (1,2) reads pixel at line 59 col 239, 1-cycle read latency.
- AVG_LOG2=2: sample run pixels 0xF800, 0x0000, 0xF800, 0x0000 -> stored R=15 (0x7800), G=0, B=0.
- VSYNC asserted after line 70 -> frame_done pulses, frame_error=1, row-2 entries unchanged from previous frame.
- start asserted while VSYNC=0 mid-frame -> WAIT_FRAME until the next VSYNC falling edge; first frame ignored; continuous=1 -> busy stays high, frame_done every frame.
- Odd byte count per line (641 bytes) -> extra byte dropped, next line's first pixel assembled correctly; XCLK high 1 of every 5 cycles throughout.
